// File: rtl/seq_bin2bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_bin2bcd_pkg
// Description : Shared display constants, converter state encoding and the
//               decimal range helper used by the BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_bin2bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Largest value representable in 'digits' decimal digits (10^digits - 1).
    function automatic logic [63:0] bcd_max_value(input int digits);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < digits; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_bin2bcd_add3.sv
`default_nettype none
// ============================================================================
// Module      : bcd_add3
// Description : Combinational double-dabble digit correction (>=5 adds 3).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3
    import seq_bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule
`default_nettype wire

// File: rtl/seq_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module      : seq_bin2bcd
// Description : Multi-cycle shift-and-add-3 binary to BCD converter with
//               start/done handshake, overflow saturation and blank mask.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_bin2bcd
    import seq_bin2bcd_pkg::*;
#(
    parameter int BIN_W    = 14,
    parameter int DIGITS   = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_start,
    input  logic [BIN_W-1:0]              i_bin,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] o_bcd,
    output logic                          o_ovf,
    output logic [DIGITS-1:0]             o_blank_mask
);

    localparam int c_ACC_W = BCD_DIGIT_W * DIGITS;
    localparam int c_CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    localparam logic [63:0] c_BIN_MAX = (BIN_W >= 64) ? {64{1'b1}}
                                                      : ((64'd1 << BIN_W) - 64'd1);
    // Overflow can only occur if the widest input exceeds the decimal range.
    localparam logic c_OVF_POSSIBLE = (DIGITS >= 20) ? 1'b0
                                    : (c_BIN_MAX > bcd_max_value(DIGITS));

    localparam logic [c_ACC_W-1:0] c_ALL_NINES = {DIGITS{4'h9}};
    localparam logic [DIGITS-1:0]  c_ONE       = DIGITS'(1);
    localparam logic [DIGITS-1:0]  c_RST_MASK  = (BLANK_LZ != 0) ? ~c_ONE : '0;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD  = c_CNT_W'(BIN_W - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [BIN_W-1:0]     r_bin;
    logic [c_ACC_W-1:0]   r_acc;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_ovf_sticky;
    logic [c_ACC_W-1:0]   r_bcd;
    logic                 r_ovf;
    logic [DIGITS-1:0]    r_blank;

    logic [c_ACC_W-1:0]   w_corr;
    logic [c_ACC_W-1:0]   w_acc_shift;
    logic                 w_carry;
    logic                 w_ovf_final;
    logic [c_ACC_W-1:0]   w_bcd_final;
    logic [DIGITS-1:0]    w_mask;
    logic                 w_accept;
    logic                 w_last;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_add3 u_add3 (
                .i_digit (r_acc [gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .o_digit (w_corr[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    assign w_acc_shift = {w_corr[c_ACC_W-2:0], r_bin[BIN_W-1]};
    assign w_carry     = w_corr[c_ACC_W-1] & c_OVF_POSSIBLE;
    assign w_ovf_final = r_ovf_sticky | w_carry;
    assign w_bcd_final = w_ovf_final ? c_ALL_NINES : w_acc_shift;

    generate
        if (BLANK_LZ != 0) begin : g_blank
            logic w_zero_above;
            always_comb begin
                w_zero_above = 1'b1;
                w_mask       = '0;
                for (int i = DIGITS - 1; i >= 1; i--) begin
                    w_zero_above = w_zero_above &
                                   (w_bcd_final[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
                    w_mask[i]    = w_zero_above;
                end
                if (w_ovf_final) begin
                    w_mask = '0;
                end
            end
        end else begin : g_no_blank
            assign w_mask = '0;
        end
    endgenerate

    assign w_accept = i_start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_state == SHIFT) && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_next = SHIFT;
            SHIFT:   if (r_cnt == '0) w_state_next = DONE;
            DONE:    w_state_next = i_start ? SHIFT : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin        <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovf_sticky <= 1'b0;
            r_bcd        <= '0;
            r_ovf        <= 1'b0;
            r_blank      <= c_RST_MASK;
        end else begin
            if (w_accept) begin
                r_bin        <= i_bin;
                r_acc        <= '0;
                r_ovf_sticky <= 1'b0;
                r_cnt        <= c_CNT_LOAD;
            end else if (r_state == SHIFT) begin
                r_acc        <= w_acc_shift;
                r_bin        <= r_bin << 1;
                r_ovf_sticky <= w_ovf_final;
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - c_CNT_W'(1);
                end
            end
            // Results are committed on the final shift so they are valid with done.
            if (w_last) begin
                r_bcd   <= w_bcd_final;
                r_ovf   <= w_ovf_final;
                r_blank <= w_mask;
            end
        end
    end

    assign o_busy       = (r_state == SHIFT);
    assign o_done       = (r_state == DONE);
    assign o_bcd        = r_bcd;
    assign o_ovf        = r_ovf;
    assign o_blank_mask = r_blank;

endmodule
`default_nettype wire
